// File: rtl/av2_tile_scheduler.sv
// av2_tile_scheduler: walks a frame in raster tile order, launching one tile
// decode at a time and waiting for its completion, with a per-tile watchdog.
// Ports:
//   clk, rst                    clock, async active-high reset
//   frame_start, abort          frame request / cancel
//   frame_width, frame_height   luma dims, latched when a frame is accepted
//   tile_start, tile_done       launch pulse to / completion pulse from decoder
//   tile_x, tile_y, tile_w, tile_h  geometry of the tile being decoded
//   busy, frame_done, timeout_err, tile_count  status
module av2_tile_scheduler #(
  parameter int unsigned TILE_SIZE     = 64,
  parameter int unsigned MAX_TILE_COLS = 8,
  parameter int unsigned MAX_TILE_ROWS = 8,
  parameter int unsigned WDOG_CYCLES   = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        abort,
  input  logic [15:0] frame_width,
  input  logic [15:0] frame_height,
  output logic        tile_start,
  output logic [15:0] tile_x,
  output logic [15:0] tile_y,
  output logic [15:0] tile_w,
  output logic [15:0] tile_h,
  input  logic        tile_done,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err,
  output logic [15:0] tile_count
);

  localparam int unsigned WDW       = $clog2(WDOG_CYCLES + 1);
  localparam logic [15:0]    TS        = 16'(TILE_SIZE);
  localparam logic [16:0]    TS_M1     = 17'(TILE_SIZE - 1);
  localparam logic [16:0]    TS17      = 17'(TILE_SIZE);
  localparam logic [16:0]    MAX_COLS  = 17'(MAX_TILE_COLS);
  localparam logic [16:0]    MAX_ROWS  = 17'(MAX_TILE_ROWS);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [15:0]     r_width, r_height, r_cols, r_rows, r_col, r_row;
  logic [15:0]     r_tile_x, r_tile_y, r_tile_w, r_tile_h, r_tile_count;
  logic [WDW-1:0]  r_wdog;
  logic            r_tile_start, r_busy, r_frame_done, r_timeout_err;

  logic            w_accept, w_zero_dim, w_last_col, w_last_tile, w_wdog_expire;
  logic [16:0]     w_cols_raw, w_rows_raw;
  logic [15:0]     w_geo_x, w_geo_y, w_geo_width, w_geo_height;
  logic [15:0]     w_rem_w, w_rem_h, w_geo_w, w_geo_h;

  assign w_accept      = (r_state == S_IDLE) && frame_start;
  assign w_zero_dim    = (frame_width == 16'd0) || (frame_height == 16'd0);
  assign w_last_col    = (r_col == r_cols - 16'd1);
  assign w_last_tile   = w_last_col && (r_row == r_rows - 16'd1);
  assign w_wdog_expire = (r_wdog == WDOG_LAST);

  // Tile grid size: ceil-divide then clamp to the supported maximum.
  assign w_cols_raw = (17'(frame_width)  + TS_M1) / TS17;
  assign w_rows_raw = (17'(frame_height) + TS_M1) / TS17;

  // Geometry of the tile about to launch: first tile when idle, else the raster successor.
  always_comb begin
    w_geo_x      = 16'd0;
    w_geo_y      = 16'd0;
    w_geo_width  = frame_width;
    w_geo_height = frame_height;
    if (r_state != S_IDLE) begin
      w_geo_width  = r_width;
      w_geo_height = r_height;
      if (w_last_col) begin
        w_geo_x = 16'd0;
        w_geo_y = r_tile_y + TS;
      end else begin
        w_geo_x = r_tile_x + TS;
        w_geo_y = r_tile_y;
      end
    end
    w_rem_w = w_geo_width  - w_geo_x;
    w_rem_h = w_geo_height - w_geo_y;
    w_geo_w = (w_rem_w > TS) ? TS : w_rem_w;
    w_geo_h = (w_rem_h > TS) ? TS : w_rem_h;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (frame_start) w_state_nx = w_zero_dim ? S_DONE : S_LAUNCH;
      S_LAUNCH: w_state_nx = S_WAIT;
      S_WAIT: begin
        if (tile_done)          w_state_nx = w_last_tile ? S_DONE : S_NEXT;
        else if (w_wdog_expire) w_state_nx = S_ERR;
      end
      S_NEXT:   w_state_nx = S_LAUNCH;
      S_DONE:   w_state_nx = S_IDLE;
      S_ERR:    w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_state_nx = S_IDLE;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_width       <= 16'd0;
      r_height      <= 16'd0;
      r_cols        <= 16'd0;
      r_rows        <= 16'd0;
      r_col         <= 16'd0;
      r_row         <= 16'd0;
      r_tile_x      <= 16'd0;
      r_tile_y      <= 16'd0;
      r_tile_w      <= 16'd0;
      r_tile_h      <= 16'd0;
      r_tile_count  <= 16'd0;
      r_wdog        <= '0;
      r_tile_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tile_start <= (w_state_nx == S_LAUNCH);
      r_busy       <= (w_state_nx != S_IDLE);
      r_frame_done <= (w_state_nx == S_DONE);

      if (w_accept) begin
        r_width       <= frame_width;
        r_height      <= frame_height;
        r_cols        <= 16'((w_cols_raw > MAX_COLS) ? MAX_COLS : w_cols_raw);
        r_rows        <= 16'((w_rows_raw > MAX_ROWS) ? MAX_ROWS : w_rows_raw);
        r_col         <= 16'd0;
        r_row         <= 16'd0;
        r_tile_x      <= 16'd0;
        r_tile_y      <= 16'd0;
        r_tile_w      <= w_geo_w;
        r_tile_h      <= w_geo_h;
        r_tile_count  <= 16'd0;
        r_timeout_err <= 1'b0;
      end

      // Geometry only moves on the way out of NEXT, so it is stable across a tile.
      if ((r_state == S_NEXT) && (w_state_nx == S_LAUNCH)) begin
        r_col    <= w_last_col ? 16'd0 : r_col + 16'd1;
        r_row    <= w_last_col ? r_row + 16'd1 : r_row;
        r_tile_x <= w_geo_x;
        r_tile_y <= w_geo_y;
        r_tile_w <= w_geo_w;
        r_tile_h <= w_geo_h;
      end

      if ((r_state == S_WAIT) && tile_done && !abort && (r_tile_count != 16'hFFFF))
        r_tile_count <= r_tile_count + 16'd1;

      if (r_state == S_LAUNCH)    r_wdog <= '0;
      else if (r_state == S_WAIT) r_wdog <= r_wdog + WDW'(1);

      if (w_state_nx == S_ERR) r_timeout_err <= 1'b1;
    end
  end

  assign tile_start  = r_tile_start;
  assign tile_x      = r_tile_x;
  assign tile_y      = r_tile_y;
  assign tile_w      = r_tile_w;
  assign tile_h      = r_tile_h;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign timeout_err = r_timeout_err;
  assign tile_count  = r_tile_count;

endmodule

// File: tb/tb_av2_tile_scheduler.sv
// tb_av2_tile_scheduler: directed self-checking bench for av2_tile_scheduler.
// Drives frames and a tile-decoder response, compares against hand-computed
// tile geometry, pulse timing and status values.
module tb_av2_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, abort, tile_done;
  logic [15:0] frame_width, frame_height;
  logic        tile_start, busy, frame_done, timeout_err;
  logic [15:0] tile_x, tile_y, tile_w, tile_h, tile_count;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          fd_cnt = 0;
  logic [63:0] geo_q[$];
  logic [63:0] exp_geo [4];

  av2_tile_scheduler #(
    .TILE_SIZE(64), .MAX_TILE_COLS(8), .MAX_TILE_ROWS(8), .WDOG_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
    .frame_width(frame_width), .frame_height(frame_height),
    .tile_start(tile_start), .tile_x(tile_x), .tile_y(tile_y),
    .tile_w(tile_w), .tile_h(tile_h), .tile_done(tile_done),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
    .tile_count(tile_count)
  );

  always #5 clk = ~clk;

  // Record launched tile geometry and frame_done pulses mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (tile_start) geo_q.push_back({tile_x, tile_y, tile_w, tile_h});
      if (frame_done) fd_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [15:0] w, input logic [15:0] h);
    frame_width  = w;
    frame_height = h;
    frame_start  = 1'b1;
    tick();
    frame_start  = 1'b0;
  endtask

  task automatic wait_start();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (tile_start) ok = 1'b1;
      else tick();
    end
    chk("start_seen", 64'(ok), 64'd1);
  endtask

  // Answer one launched tile after dly cycles, then check the follow-up timing.
  task automatic serve_tile(input int dly, input bit last, input int exp_cnt);
    wait_start();
    repeat (dly) tick();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    chk("tile_count", 64'(tile_count), 64'(exp_cnt));
    if (last) begin
      chk("frame_done_pulse", 64'(frame_done), 64'd1);
      tick();
      chk("busy_off", 64'(busy), 64'd0);
      chk("frame_done_1cyc", 64'(frame_done), 64'd0);
    end else begin
      chk("gap_no_start", 64'(tile_start), 64'd0);
      tick();
      chk("relaunch_2cyc", 64'(tile_start), 64'd1);
    end
  endtask

  task automatic do_frame(input logic [15:0] w, input logic [15:0] h,
                          input int n_tiles, input int dly);
    geo_q.delete();
    fd_cnt = 0;
    start_frame(w, h);
    chk("launch_next_cycle", 64'(tile_start), 64'd1);
    chk("busy_on", 64'(busy), 64'd1);
    chk("terr_clear", 64'(timeout_err), 64'd0);
    for (int t = 0; t < n_tiles; t++) serve_tile(dly, t == n_tiles - 1, t + 1);
    chk("n_tiles", 64'(geo_q.size()), 64'(n_tiles));
    chk("frame_done_cnt", 64'(fd_cnt), 64'd1);
  endtask

  task automatic chk_geo4(input string tag);
    chk({tag, "_size"}, 64'(geo_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < geo_q.size()) chk($sformatf("%s_geo%0d", tag, i), geo_q[i], exp_geo[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; abort = 1'b0; tile_done = 1'b0;
    frame_width = 16'd0; frame_height = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", 64'({tile_start, busy, frame_done, timeout_err}), 64'd0);
    chk("rst_geo", {tile_x, tile_y, tile_w, tile_h}, 64'd0);
    chk("rst_count", 64'(tile_count), 64'd0);
    rst = 1'b0;
    tick();

    // 128x128, decoder answers 5 cycles after each launch
    exp_geo[0] = {16'd0,  16'd0,  16'd64, 16'd64};
    exp_geo[1] = {16'd64, 16'd0,  16'd64, 16'd64};
    exp_geo[2] = {16'd0,  16'd64, 16'd64, 16'd64};
    exp_geo[3] = {16'd64, 16'd64, 16'd64, 16'd64};
    do_frame(16'd128, 16'd128, 4, 5);
    chk_geo4("f128");

    // 100x70: partial right column and bottom row
    exp_geo[0] = {16'd0,  16'd0,  16'd64, 16'd64};
    exp_geo[1] = {16'd64, 16'd0,  16'd36, 16'd64};
    exp_geo[2] = {16'd0,  16'd64, 16'd64, 16'd6};
    exp_geo[3] = {16'd64, 16'd64, 16'd36, 16'd6};
    do_frame(16'd100, 16'd70, 4, 2);
    chk_geo4("f100x70");

    // 1000x10: 16 columns clamp to 8, all full width, 10 rows high
    do_frame(16'd1000, 16'd10, 8, 1);
    if (geo_q.size() == 8) begin
      chk("clamp_first", geo_q[0], {16'd0,   16'd0, 16'd64, 16'd10});
      chk("clamp_last",  geo_q[7], {16'd448, 16'd0, 16'd64, 16'd10});
    end

    // Watchdog: tile never completes, 20 WAIT cycles then ERR
    fd_cnt = 0;
    start_frame(16'd64, 16'd64);
    chk("wd_launch", 64'(tile_start), 64'd1);
    repeat (20) tick();
    chk("wd_not_yet", 64'(timeout_err), 64'd0);
    tick();
    chk("wd_err_set", 64'(timeout_err), 64'd1);
    tick();
    chk("wd_busy_off", 64'(busy), 64'd0);
    chk("wd_err_sticky", 64'(timeout_err), 64'd1);
    repeat (3) tick();
    chk("wd_err_hold", 64'(timeout_err), 64'd1);
    chk("wd_no_frame_done", 64'(fd_cnt), 64'd0);
    do_frame(16'd64, 16'd64, 1, 3);

    // Abort together with tile_done of tile 2 of 4
    geo_q.delete();
    fd_cnt = 0;
    start_frame(16'd128, 16'd128);
    serve_tile(3, 1'b0, 1);
    tick();
    tick();
    tile_done = 1'b1;
    abort     = 1'b1;
    tick();
    tile_done = 1'b0;
    abort     = 1'b0;
    chk("abort_busy_off", 64'(busy), 64'd0);
    chk("abort_count", 64'(tile_count), 64'd1);
    repeat (10) tick();
    chk("abort_no_more_start", 64'(geo_q.size()), 64'd2);
    chk("abort_no_frame_done", 64'(fd_cnt), 64'd0);

    // Zero width: straight to DONE, no launch
    geo_q.delete();
    fd_cnt = 0;
    start_frame(16'd0, 16'd100);
    chk("zero_frame_done", 64'(frame_done), 64'd1);
    chk("zero_no_start", 64'(tile_start), 64'd0);
    tick();
    chk("zero_busy_off", 64'(busy), 64'd0);
    chk("zero_count", 64'(tile_count), 64'd0);
    chk("zero_starts", 64'(geo_q.size()), 64'd0);
    chk("zero_fd_cnt", 64'(fd_cnt), 64'd1);

    // Re-pulsed frame_start and tile_done during LAUNCH are both ignored
    exp_geo[0] = {16'd0,  16'd0,  16'd64, 16'd64};
    exp_geo[1] = {16'd64, 16'd0,  16'd36, 16'd64};
    exp_geo[2] = {16'd0,  16'd64, 16'd64, 16'd6};
    exp_geo[3] = {16'd64, 16'd64, 16'd36, 16'd6};
    geo_q.delete();
    fd_cnt = 0;
    start_frame(16'd100, 16'd70);
    chk("ign_launch", 64'(tile_start), 64'd1);
    tile_done    = 1'b1;
    frame_start  = 1'b1;
    frame_width  = 16'd300;
    frame_height = 16'd300;
    tick();
    tile_done = 1'b0;
    chk("ign_done_in_launch", 64'(tile_count), 64'd0);
    tick();
    frame_start = 1'b0;
    tick();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    chk("ign_count1", 64'(tile_count), 64'd1);
    tick();
    chk("ign_relaunch", 64'(tile_start), 64'd1);
    serve_tile(2, 1'b0, 2);
    serve_tile(2, 1'b0, 3);
    serve_tile(2, 1'b1, 4);
    chk_geo4("ign");
    chk("ign_fd_cnt", 64'(fd_cnt), 64'd1);

    // Reset mid-frame: frame abandoned, no frame_done afterwards
    fd_cnt = 0;
    start_frame(16'd128, 16'd128);
    repeat (3) tick();
    rst = 1'b1;
    #2;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_geo", {tile_x, tile_y, tile_w, tile_h}, 64'd0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_mid_no_fd", 64'(fd_cnt), 64'd0);
    chk("rst_mid_idle", 64'({busy, tile_start}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
